seven_scan_mux: RTL
===================

SEVEN_SCAN_MUX -- requirements
Module: seven_scan_mux

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4: digit count, legal 1..8.
REQ-002 SHALL have parameter CLK_DIV, default 50000: clk cycles per digit slot, legal >= 4.
REQ-003 SHALL have parameter DUTY_BITS, default 3: brightness field width, legal 1..4.
REQ-004 SHALL have port clk  input  1: single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1: asynchronous, active-high reset.
REQ-006 SHALL have port big_bin  input  4*NUM_DIGITS: nibble k drives digit k, digit 0 = least significant.
REQ-007 SHALL have port dp_in  input  NUM_DIGITS: decimal point request per digit, 1 = lit.
REQ-008 SHALL have port blank_mask  input  NUM_DIGITS: 1 = digit forced dark.
REQ-009 SHALL have port lz_suppress  input  1: 1 = leading-zero blanking enabled.
REQ-010 SHALL have port brightness  input  DUTY_BITS: anode duty control.
REQ-011 SHALL have port AN  output  NUM_DIGITS: anodes, active-low, registered.
REQ-012 SHALL have port seg  output  7: segments a..g in bits 0..6, active-low, registered.
REQ-013 SHALL have port dp  output  1: decimal point cathode, active-low, registered.
REQ-014 SHALL have port frame_tick  output  1: one-cycle pulse at each frame start.

Function
REQ-015 Prescaler SHALL count 0..CLK_DIV-1 and wrap; wrap cycle is the slot-advance event.
REQ-016 Digit index SHALL advance 0,1,..,NUM_DIGITS-1,0 on each slot-advance, wrapping at NUM_DIGITS-1.
REQ-017 On index wrap to 0, big_bin, dp_in, blank_mask, lz_suppress, brightness SHALL be captured into shadow registers; display uses only shadow values for the whole frame (no tearing).
REQ-018 frame_tick SHALL be high exactly the cycle after the shadow capture, once per NUM_DIGITS*CLK_DIV cycles.
REQ-019 Slot cycle with prescaler==0 SHALL be a dead cycle: AN all ones (ghosting guard).
REQ-020 Free-running DUTY_BITS PWM counter SHALL increment every clk; anode of current digit active only when pwm_count <= shadow brightness (max value = 100% duty, 0 = 1/2^DUTY_BITS).
REQ-021 Leading-zero suppression: with shadow lz_suppress=1, every digit above the most significant nonzero nibble SHALL be dark; digit 0 SHALL never be suppressed; dp of a suppressed digit also dark.
REQ-022 A digit dark by blank_mask or suppression SHALL drive AN bit high for its whole slot; seg and dp all ones.
REQ-023 seg SHALL be hex 0..F decode of current shadow nibble, standard 7-segment glyphs (b,d lowercase).
REQ-024 AN, seg, dp SHALL update one clk after the index/prescaler state that selects them (fixed latency 1).
REQ-025 At most one AN bit SHALL be low in any cycle.
REQ-026 NUM_DIGITS=1 SHALL be legal: index constant 0, shadow capture every slot.

Reset
REQ-027 rst high SHALL immediately force AN all ones, seg 7'h7F, dp 1, frame_tick 0.
REQ-028 rst SHALL clear prescaler, digit index, PWM counter and all shadow registers to 0.
REQ-029 First frame after rst release SHALL start at digit 0 with shadow capture on the first cycle; rst mid-frame abandons the frame with no partial output.

Structure
REQ-030 Shared package seven_pkg SHALL hold the 16-entry active-low segment table and segment bit-order constants.
REQ-031 Nibble-to-segment decode SHALL be sub-module seg7_decode (combinational, 4 in, 7 out), instantiated once.
REQ-032 Prescaler width SHALL be $clog2(CLK_DIV); index width $clog2(NUM_DIGITS) min 1.

Verification (NUM_DIGITS=4, CLK_DIV=4, DUTY_BITS=3)
REQ-033 big_bin=16'h12AF, masks 0, brightness=7 -> AN cycles 1110,1101,1011,0111 each 3 of 4 cycles with dead cycle; seg = F,A,2,1 glyphs.
REQ-034 big_bin=16'h0005, lz_suppress=1 -> only digit 0 lit ("5"); lz_suppress=0 -> "0005".
REQ-035 brightness=0 -> each lit anode low only when PWM count is 0, i.e. 1 of 8 cycles; brightness=3 -> 4 of 8.
REQ-036 Change big_bin mid-frame from 16'h1111 to 16'h2222 -> remaining digits still show 1; next frame all 2; frame_tick pulses once per 16 cycles.
REQ-037 Assert rst during digit 2 -> same-cycle AN=1111, seg=7F; after release display restarts at digit 0 with frame_tick.
REQ-038 dp_in=4'b0100, blank_mask=4'b1000 -> dp low only in digit 2 slot; AN[3] never low.

Source files
------------

// File: rtl/seven_pkg.sv
// Shared constants for the seven-segment scan multiplexer: segment bit order
// and the active-low hex glyph table (bit 0 = segment a ... bit 6 = segment g).
package seven_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low glyphs 0..F; b and d are the lowercase forms.
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble to active-low seven-segment decode.
module seg7_decode
  import seven_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_LUT[nibble_i];
  end

endmodule

// File: rtl/seven_scan_mux.sv
// Time-multiplexed seven-segment driver: per-frame shadowed inputs, dead-cycle
// ghosting guard, PWM brightness and leading-zero blanking.
module seven_scan_mux
  import seven_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_DIV    = 50000,
  parameter int DUTY_BITS  = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] big_bin,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic                    lz_suppress,
  input  logic [DUTY_BITS-1:0]    brightness,
  output logic [NUM_DIGITS-1:0]   AN,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_tick
);

  localparam int PRE_W = $clog2(CLK_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [PRE_W-1:0]        presc_q, presc_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [DUTY_BITS-1:0]    pwm_q, pwm_d;
  logic                    first_q;
  logic [4*NUM_DIGITS-1:0] sh_bin_q;
  logic [NUM_DIGITS-1:0]   sh_dp_q;
  logic [NUM_DIGITS-1:0]   sh_blank_q;
  logic                    sh_lz_q;
  logic [DUTY_BITS-1:0]    sh_bright_q;

  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic                    ft_q;

  logic                    slot_adv;
  logic                    idx_wrap;
  logic                    capture;

  logic [3:0]              nib_sel;
  logic                    dp_sel;
  logic                    blank_sel;
  logic                    lz_sel;
  logic                    seen_nz;
  logic                    dead;
  logic                    dark;
  logic                    lit;
  logic [6:0]              seg_raw;

  // Scan timing: prescaler, digit index, free-running PWM counter.
  always_comb begin
    slot_adv = (presc_q == PRE_W'(CLK_DIV - 1));
    idx_wrap = slot_adv && (idx_q == IDX_W'(NUM_DIGITS - 1));
    presc_d  = slot_adv ? '0 : presc_q + 1'b1;
    idx_d    = idx_q;
    if (slot_adv) begin
      idx_d = idx_wrap ? '0 : idx_q + 1'b1;
    end
    pwm_d    = pwm_q + 1'b1;
    // The first cycle after reset loads the shadows so frame one shows real data.
    capture  = first_q | idx_wrap;
  end

  // Per-digit selection from the shadow copy; seen_nz sweeps from the top
  // digit down so a digit is a leading zero when nothing at or above it is set.
  always_comb begin
    nib_sel   = 4'h0;
    dp_sel    = 1'b0;
    blank_sel = 1'b0;
    lz_sel    = 1'b0;
    seen_nz   = 1'b0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      seen_nz = seen_nz | (sh_bin_q[4*k +: 4] != 4'h0);
      if (idx_q == IDX_W'(k)) begin
        nib_sel   = sh_bin_q[4*k +: 4];
        dp_sel    = sh_dp_q[k];
        blank_sel = sh_blank_q[k];
        lz_sel    = !seen_nz && (k != 0);
      end
    end
  end

  seg7_decode u_dec (
    .nibble_i (nib_sel),
    .seg_o    (seg_raw)
  );

  always_comb begin
    dead  = (presc_q == '0);
    dark  = blank_sel | (sh_lz_q & lz_sel);
    lit   = !dead && !dark && (pwm_q <= sh_bright_q);
    an_d  = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (lit && (idx_q == IDX_W'(k))) begin
        an_d[k] = 1'b0;
      end
    end
    seg_d = (dead || dark) ? SEG_BLANK : seg_raw;
    dp_d  = (dead || dark) ? 1'b1 : ~dp_sel;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q     <= '0;
      idx_q       <= '0;
      pwm_q       <= '0;
      first_q     <= 1'b1;
      sh_bin_q    <= '0;
      sh_dp_q     <= '0;
      sh_blank_q  <= '0;
      sh_lz_q     <= 1'b0;
      sh_bright_q <= '0;
      an_q        <= '1;
      seg_q       <= SEG_BLANK;
      dp_q        <= 1'b1;
      ft_q        <= 1'b0;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      pwm_q   <= pwm_d;
      first_q <= 1'b0;
      if (capture) begin
        sh_bin_q    <= big_bin;
        sh_dp_q     <= dp_in;
        sh_blank_q  <= blank_mask;
        sh_lz_q     <= lz_suppress;
        sh_bright_q <= brightness;
      end
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
      ft_q  <= capture;
    end
  end

  assign AN         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_tick = ft_q;

endmodule
